mod_exp_ctrl: RTL and testbench

Sequencer for one shared Montgomery multiplier. It computes base^exp mod n with left-to-right binary square-and-multiply, issuing one multiply at a time over a start/done handshake. It sits between the RSA top-level (host) and the Montgomery multiplier engine. The host supplies operands already in the Montgomery domain; the block applies the final conversion out of the domain itself.

---
 rtl/mod_exp_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery multiplier.
// Build option: define MODEXP_CONST_TIME_EN for the exponent-independent multiply schedule.
module mod_exp_ctrl #(
   parameter int WIDTH = 2048,
   parameter int EXP_W = 2048
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base_m,
   input  logic [WIDTH-1:0] one_m,
   input  logic [EXP_W-1:0] exponent,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             mm_start,
   output logic [WIDTH-1:0] mm_a,
   output logic [WIDTH-1:0] mm_b,
   input  logic             mm_done,
   input  logic [WIDTH-1:0] mm_result
);

   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_SCAN      = 4'd1;
   localparam logic [3:0] S_SQR_REQ   = 4'd2;
   localparam logic [3:0] S_SQR_WAIT  = 4'd3;
   localparam logic [3:0] S_MUL_REQ   = 4'd4;
   localparam logic [3:0] S_MUL_WAIT  = 4'd5;
   localparam logic [3:0] S_CONV_REQ  = 4'd6;
   localparam logic [3:0] S_CONV_WAIT = 4'd7;
   localparam logic [3:0] S_DONE      = 4'd8;

   logic [3:0]       state_q,    state_d;
   logic [IDX_W-1:0] idx_q,      idx_d;
   logic [EXP_W-1:0] exp_q,      exp_d;
   logic [WIDTH-1:0] base_q,     base_d;
   logic [WIDTH-1:0] acc_q,      acc_d;
   logic [WIDTH-1:0] result_q,   result_d;
   logic [WIDTH-1:0] mm_a_q,     mm_a_d;
   logic [WIDTH-1:0] mm_b_q,     mm_b_d;
   logic             mm_start_q, mm_start_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;
   logic             bit_set;
   logic             idx_last;

   assign bit_set  = exp_q[idx_q];
   assign idx_last = (idx_q == '0);

   always_comb begin
      // NOTE: every _d starts as its _q so no branch can leave a signal unassigned (no latches).
      state_d    = state_q;
      idx_d      = idx_q;
      exp_d      = exp_q;
      base_d     = base_q;
      acc_d      = acc_q;
      result_d   = result_q;
      mm_a_d     = mm_a_q;
      mm_b_d     = mm_b_q;
      mm_start_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d = base_m;
               exp_d  = exponent;
               acc_d  = one_m;
               idx_d  = IDX_TOP;
`ifdef MODEXP_CONST_TIME_EN
               state_d = S_SQR_REQ;
`else
               state_d = S_SCAN;
`endif
            end
         end

         S_SCAN: begin
            if (bit_set) begin
               state_d = S_SQR_REQ;
            end else if (!idx_last) begin
               idx_d = idx_q - 1'b1;
            end else begin
               state_d = S_CONV_REQ;
            end
         end

         S_SQR_REQ: state_d = S_SQR_WAIT;

         S_SQR_WAIT: begin
            if (mm_done) begin
               acc_d = mm_result;
`ifdef MODEXP_CONST_TIME_EN
               state_d = S_MUL_REQ;
`else
               if (bit_set) begin
                  state_d = S_MUL_REQ;
               end else if (!idx_last) begin
                  idx_d   = idx_q - 1'b1;
                  state_d = S_SQR_REQ;
               end else begin
                  state_d = S_CONV_REQ;
               end
`endif
            end
         end

         S_MUL_REQ: state_d = S_MUL_WAIT;

         S_MUL_WAIT: begin
            if (mm_done) begin
`ifdef MODEXP_CONST_TIME_EN
               // Dummy multiply on a zero bit: product is computed but dropped.
               if (bit_set) begin
                  acc_d = mm_result;
               end
`else
               acc_d = mm_result;
`endif
               if (!idx_last) begin
                  idx_d   = idx_q - 1'b1;
                  state_d = S_SQR_REQ;
               end else begin
                  state_d = S_CONV_REQ;
               end
            end
         end

         S_CONV_REQ: state_d = S_CONV_WAIT;

         S_CONV_WAIT: begin
            if (mm_done) begin
               result_d = mm_result;
               state_d  = S_DONE;
            end
         end

         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Operands are loaded on entry to a request state from acc_d, so a product
      // arriving this cycle feeds the next request and stays put through the wait.
      case (state_d)
         S_SQR_REQ: begin
            mm_start_d = 1'b1;
            mm_a_d     = acc_d;
            mm_b_d     = acc_d;
         end
         S_MUL_REQ: begin
            mm_start_d = 1'b1;
            mm_a_d     = acc_d;
            mm_b_d     = base_d;
         end
         S_CONV_REQ: begin
            mm_start_d = 1'b1;
            mm_a_d     = acc_d;
            mm_b_d     = WIDTH'(1);
         end
         default: ;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= IDX_TOP;
         exp_q      <= '0;
         base_q     <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         mm_a_q     <= '0;
         mm_b_q     <= '0;
         mm_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         exp_q      <= exp_d;
         base_q     <= base_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         mm_a_q     <= mm_a_d;
         mm_b_q     <= mm_b_d;
         mm_start_q <= mm_start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign mm_start = mm_start_q;
   assign mm_a     = mm_a_q;
   assign mm_b     = mm_b_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl at WIDTH=EXP_W=8, n=13 (R=256, R mod 13 = 9, R^-1 mod 13 = 3).
// Honours MODEXP_CONST_TIME_EN for the expected multiply counts.
module tb_mod_exp_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] base_m;
   logic [W-1:0] one_m;
   logic [W-1:0] exponent;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         mm_start;
   logic [W-1:0] mm_a;
   logic [W-1:0] mm_b;
   logic         mm_done;
   logic [W-1:0] mm_result;

   logic         m_done;
   logic         inj_done;
   logic         pend;
   int           cnt;
   int           mm_lat;
   logic [W-1:0] cap_a;
   logic [W-1:0] cap_b;
   logic [W-1:0] m_res;

   int n_tests = 0;
   int n_fail  = 0;

   mod_exp_ctrl #(.WIDTH(W), .EXP_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_m    (base_m),
      .one_m     (one_m),
      .exponent  (exponent),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .mm_start  (mm_start),
      .mm_a      (mm_a),
      .mm_b      (mm_b),
      .mm_done   (mm_done),
      .mm_result (mm_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mm_done   = m_done | inj_done;
   assign mm_result = m_res;

   // Montgomery multiplier model: a*b*R^-1 mod 13, done pulse mm_lat cycles after mm_start.
   always @(posedge clk) begin
      if (rst) begin
         pend   <= 1'b0;
         m_done <= 1'b0;
         cnt    <= 0;
      end else begin
         m_done <= 1'b0;
         if (mm_start) begin
            cap_a <= mm_a;
            cap_b <= mm_b;
            m_res <= 8'((int'(mm_a) * int'(mm_b) * 3) % 13);
            if (mm_lat <= 1) begin
               m_done <= 1'b1;
            end else begin
               pend <= 1'b1;
               cnt  <= mm_lat - 1;
            end
         end else if (pend) begin
            if (cnt == 1) begin
               m_done <= 1'b1;
               pend   <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic int mm_count(input int dyn);
`ifdef MODEXP_CONST_TIME_EN
      return 17;
`else
      return dyn;
`endif
   endfunction

   // One operation; optional stray start / stray mm_done at cycle k, optional reset after N requests.
   task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input int lat,
                         input int inj_start_k, input int inj_done_k, input int rst_after,
                         output logic [W-1:0] res, output int n_st, output int n_dn,
                         output int n_uns, output bit timed_out);
      int  k;
      int  tail;
      bit  seen;
      bit  rst_pend;
      mm_lat   = lat;
      base_m   = b;
      one_m    = 8'd9;
      exponent = e;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      n_st = 0; n_dn = 0; n_uns = 0;
      k = 0; tail = 0; seen = 1'b0; rst_pend = 1'b0;
      while (tail < 3 && k < 2000) begin
         @(negedge clk);
         k++;
         if (rst_pend) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            seen = 1'b1;
            break;
         end
         if (mm_start) n_st++;
         if (done) n_dn++;
         if ((pend || m_done) && (mm_a !== cap_a || mm_b !== cap_b)) n_uns++;
         if (rst_after > 0 && n_st == rst_after) rst_pend = 1'b1;
         if (done) seen = 1'b1;
         if (seen) tail++;
         start    = (k == inj_start_k);
         inj_done = (k == inj_done_k);
         if (k == inj_start_k) begin
            base_m   = 8'd4;
            exponent = 8'd255;
         end
      end
      start     = 1'b0;
      inj_done  = 1'b0;
      res       = result;
      timed_out = !seen;
   endtask

   typedef struct {
      logic [W-1:0] base_m;
      logic [W-1:0] exp;
      int           lat;
      logic [W-1:0] res;
      int           n_mm;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [W-1:0] res;
      int           n_st, n_dn, n_uns, n_idle_st;
      bit           to;

      // base_m 5 = 2 in the Montgomery domain, base_m 4 = 12.
      vecs[0] = '{8'd5, 8'd5,   3, 8'd6,  6};
      vecs[1] = '{8'd5, 8'd0,   3, 8'd1,  1};
      vecs[2] = '{8'd4, 8'd1,   3, 8'd12, 3};
      vecs[3] = '{8'd4, 8'd3,   1, 8'd12, 5};
      vecs[4] = '{8'd5, 8'd255, 1, 8'd8,  17};
      vecs[5] = '{8'd5, 8'd128, 2, 8'd9,  10};
      vecs[6] = '{8'd4, 8'd2,   1, 8'd1,  4};

      rst = 1'b1; start = 1'b0; inj_done = 1'b0; mm_lat = 3;
      base_m = '0; one_m = '0; exponent = '0;
      repeat (3) @(negedge clk);
      check("reset busy",     int'(busy),     0);
      check("reset done",     int'(done),     0);
      check("reset mm_start", int'(mm_start), 0);
      check("reset result",   int'(result),   0);
      check("reset mm_a",     int'(mm_a),     0);
      check("reset mm_b",     int'(mm_b),     0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].base_m, vecs[i].exp, vecs[i].lat, -1, -1, 0, res, n_st, n_dn, n_uns, to);
         check($sformatf("vec%0d timeout", i),  int'(to), 0);
         check($sformatf("vec%0d result", i),   int'(res), int'(vecs[i].res));
         check($sformatf("vec%0d done cnt", i), n_dn, 1);
         check($sformatf("vec%0d mm_start cnt", i), n_st, mm_count(vecs[i].n_mm));
         check($sformatf("vec%0d operand hold", i), n_uns, 0);
      end

      repeat (5) @(negedge clk);
      check("result held in idle", int'(result), 1);

      // Stray start while busy and stray mm_done early in the run must both be ignored.
`ifdef MODEXP_CONST_TIME_EN
      run_op(8'd5, 8'd5, 3, 9, -1, 0, res, n_st, n_dn, n_uns, to);
`else
      run_op(8'd5, 8'd5, 3, 9, 2, 0, res, n_st, n_dn, n_uns, to);
`endif
      check("stray timeout",      int'(to), 0);
      check("stray result",       int'(res), 6);
      check("stray done cnt",     n_dn, 1);
      check("stray mm_start cnt", n_st, mm_count(6));

      // Reset while the first multiply (second request) is outstanding.
      run_op(8'd5, 8'd5, 3, -1, -1, 2, res, n_st, n_dn, n_uns, to);
      check("abort busy",     int'(busy),     0);
      check("abort done",     int'(done),     0);
      check("abort mm_start", int'(mm_start), 0);
      check("abort result",   int'(result),   0);
      n_idle_st = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (mm_start || busy) n_idle_st++;
      end
      check("abort stays idle", n_idle_st, 0);

      run_op(8'd5, 8'd5, 3, -1, -1, 0, res, n_st, n_dn, n_uns, to);
      check("post-abort timeout",  int'(to), 0);
      check("post-abort result",   int'(res), 6);
      check("post-abort mm_start", n_st, mm_count(6));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
